// File: rtl/nor_bist_ctrl.sv
// nor_bist_ctrl: BIST controller driving {a,b} = 00..11 into NUM_UUT NOR units and flagging mismatches.
// Define NOR_BIST_ERRCNT_EN to add the saturating err_cnt output.
module nor_bist_ctrl #(
  parameter int HOLD    = 2,
  parameter int NUM_UUT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               a,
  output logic               b,
  input  logic [NUM_UUT-1:0] y,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [NUM_UUT-1:0] fail_mask
`ifdef NOR_BIST_ERRCNT_EN
  ,
  output logic [3:0]         err_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;
  state_t             state_q;
  logic [1:0]         idx_q;
  logic [3:0]         hold_q;
  logic               a_q, b_q, busy_q, done_q, pass_q;
  logic [NUM_UUT-1:0] fail_q, fail_d, mis;
  logic               exp_v;
  assign a         = a_q;
  assign b         = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_mask = fail_q;
  // Case-inequality so X/Z on a unit output counts as a mismatch in simulation.
  always_comb begin
    exp_v = ~(a_q | b_q);
    mis   = '0;
    for (int i = 0; i < NUM_UUT; i++) mis[i] = (y[i] !== exp_v);
    fail_d = fail_q | mis;
  end
`ifdef NOR_BIST_ERRCNT_EN
  logic [3:0] err_q, err_d, cnt;
  logic [4:0] sum;
  assign err_cnt = err_q;
  always_comb begin
    cnt = '0;
    for (int i = 0; i < NUM_UUT; i++) cnt = cnt + 4'(mis[i]);
    sum   = {1'b0, err_q} + {1'b0, cnt};
    err_d = (sum > 5'd15) ? 4'd15 : sum[3:0];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_q <= '0;
    else if (state_q == IDLE && start) err_q <= '0;
    else if (state_q == CHECK) err_q <= err_d;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q <= DRIVE;
          idx_q   <= '0;
          hold_q  <= 4'(HOLD - 1);
          {a_q, b_q} <= 2'b00;
          busy_q  <= 1'b1;
          pass_q  <= 1'b0;
          fail_q  <= '0;
        end
        DRIVE: if (hold_q == '0) state_q <= CHECK;
               else hold_q <= hold_q - 4'd1;
        CHECK: begin
          fail_q <= fail_d;
          if (idx_q == 2'd3) begin
            state_q    <= DONE;
            {a_q, b_q} <= 2'b00;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            pass_q     <= (fail_d == '0);
          end else begin
            state_q    <= DRIVE;
            idx_q      <= idx_q + 2'd1;
            {a_q, b_q} <= idx_q + 2'd1;
            hold_q     <= 4'(HOLD - 1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_nor_bist_ctrl.sv
// tb_nor_bist_ctrl: directed and random runs of nor_bist_ctrl against emulated NOR units.
module tb_nor_bist_ctrl;
  localparam int N = 4, HOLD = 2;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [N-1:0] y, fail_mask;
  logic a, b, busy, done, pass;
`ifdef NOR_BIST_ERRCNT_EN
  logic [3:0] err_cnt;
`endif
  int kinds[N];
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  nor_bist_ctrl #(.HOLD(HOLD), .NUM_UUT(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .y(y),
    .busy(busy), .done(done), .pass(pass), .fail_mask(fail_mask)
`ifdef NOR_BIST_ERRCNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  // Unit kinds: 0 NOR, 1 OR, 2 stuck-1, 3 stuck-0, 4 X, 5 AND, 6 XNOR.
  always_comb begin
    y = '0;
    for (int i = 0; i < N; i++)
      case (kinds[i])
        0: y[i] = ~(a | b);
        1: y[i] = a | b;
        2: y[i] = 1'b1;
        3: y[i] = 1'b0;
        4: y[i] = 1'bx;
        5: y[i] = a & b;
        default: y[i] = ~(a ^ b);
      endcase
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_a"}, {7'd0, a}, 8'd0);
    chk({tag, "_b"}, {7'd0, b}, 8'd0);
    chk({tag, "_busy"}, {7'd0, busy}, 8'd0);
    chk({tag, "_done"}, {7'd0, done}, 8'd0);
    chk({tag, "_pass"}, {7'd0, pass}, 8'd0);
    chk({tag, "_mask"}, {4'd0, fail_mask}, 8'd0);
`ifdef NOR_BIST_ERRCNT_EN
    chk({tag, "_err"}, {4'd0, err_cnt}, 8'd0);
`endif
  endtask

  // One run: pattern k occupies cycles 3k+1..3k+3, its check is cycle 3k+3, done in cycle 13.
  task automatic run(input int restart_at, input int rst_at);
    logic [N-1:0] em;
    int cnt, p;
    logic ea, eb;
    em = '0;
    cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      if (c == restart_at) start = 1'b1;
      if (c == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk_zero("rst_mid");
        tick();
        chk("rst_nodone", {7'd0, done}, 8'd0);
        rst_n = 1'b1;
        return;
      end
      p  = (c - 1) / 3;
      ea = (c <= 12) ? p[1] : 1'b0;
      eb = (c <= 12) ? p[0] : 1'b0;
      chk("a", {7'd0, a}, {7'd0, ea});
      chk("b", {7'd0, b}, {7'd0, eb});
      chk("busy", {7'd0, busy}, {7'd0, c <= 12});
      chk("done", {7'd0, done}, {7'd0, c == 13});
      if (c <= 12 && c % 3 == 0)
        for (int i = 0; i < N; i++)
          if (y[i] !== ~(ea | eb)) begin
            em[i] = 1'b1;
            cnt++;
          end
      tick();
      start = 1'b0;
    end
    chk("end_done", {7'd0, done}, 8'd0);
    chk("end_busy", {7'd0, busy}, 8'd0);
    chk("pass", {7'd0, pass}, {7'd0, em == '0});
    chk("mask", {4'd0, fail_mask}, {4'd0, em});
`ifdef NOR_BIST_ERRCNT_EN
    chk("err", {4'd0, err_cnt}, 8'(cnt > 15 ? 15 : cnt));
`endif
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("idle_busy", {7'd0, busy}, 8'd0);
      chk("hold_mask", {4'd0, fail_mask}, {4'd0, em});
    end
  endtask

  task automatic set_all(input int k);
    for (int i = 0; i < N; i++) kinds[i] = k;
  endtask

  initial begin
    set_all(0);
    #2;
    chk_zero("reset");
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("idle_nostart", {7'd0, busy}, 8'd0);
    end
    run(0, 0);
    set_all(0); kinds[2] = 1;
    run(0, 0);
    set_all(0); kinds[0] = 2;
    run(0, 0);
    set_all(4);
    run(0, 0);
    set_all(0);
    run(5, 0);
    run(0, 7);
    chk_zero("after_rst");
    run(0, 0);
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++) kinds[i] = int'($urandom_range(0, 6));
      run(0, 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/nor_bist_ctrl.md
NOR_BIST_CTRL -- requirements
Module: nor_bist_ctrl

Interface
REQ-001 SHALL have parameter HOLD, default 2, meaning clock cycles each input pattern is held before its outputs are sampled (legal range 1..15).
REQ-002 SHALL have parameter NUM_UUT, default 4, meaning number of NOR implementations checked in parallel (legal range 1..8).
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk and rst_n.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  request a test run; sampled only in IDLE.
REQ-007 SHALL have port a  output  1  stimulus bit a, broadcast to all units under test.
REQ-008 SHALL have port b  output  1  stimulus bit b, broadcast to all units under test.
REQ-009 SHALL have port y  input  NUM_UUT  outputs of the units under test; bit i comes from unit i.
REQ-010 SHALL have port busy  output  1  high while a run is in progress (DRIVE or CHECK).
REQ-011 SHALL have port done  output  1  one-cycle pulse at the end of a run.
REQ-012 SHALL have port pass  output  1  high when the last run found no mismatch.
REQ-013 SHALL have port fail_mask  output  NUM_UUT  sticky per-unit mismatch flags for the current or last run.

Function
REQ-014 SHALL implement the states IDLE, DRIVE, CHECK and DONE, held in a registered state variable.
REQ-015 In IDLE, start=1 at a rising edge SHALL do the following: clear fail_mask and pass, set pattern index to 0, load the hold counter with HOLD-1, and go to DRIVE.
REQ-016 In IDLE, start=0 SHALL keep the block in IDLE.
REQ-017 In any state other than IDLE, start SHALL be ignored; there is no queuing.
REQ-018 The pattern index is a 2-bit counter; a and b SHALL be registered as {a,b} = index, giving the sequence 00, 01, 10, 11.
REQ-019 In IDLE and DONE, a and b SHALL be 0.
REQ-020 DRIVE SHALL decrement the hold counter each cycle and go to CHECK on the cycle it reads 0, so DRIVE lasts exactly HOLD cycles.
REQ-021 CHECK SHALL last one cycle and compare each y[i] with the expected value ~(a|b).
REQ-022 In CHECK, any y[i] not equal to the expected value SHALL set fail_mask[i]; this includes X or Z values, using case-inequality in simulation.
REQ-023 fail_mask bits SHALL only be set during a run, never cleared during a run.
REQ-024 From CHECK with index<3, the block SHALL increment the index, reload the hold counter and return to DRIVE.
REQ-025 From CHECK with index=3, the block SHALL go to DONE; the index does not wrap inside a run.
REQ-026 DONE SHALL last one cycle with done=1, load pass = (fail_mask==0) including the last CHECK result, and then go to IDLE.
REQ-027 Latency: done SHALL be high in cycle 4*(HOLD+1)+1 counted from the start-sampling edge; with HOLD=2 this is cycle 13.
REQ-028 pass and fail_mask SHALL hold their values after DONE until the next accepted start.
REQ-029 busy SHALL be high exactly in DRIVE and CHECK.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 rst_n=0 SHALL force, asynchronously and at any time including mid-run: state=IDLE, index=0, hold counter=0, a=b=0, busy=0, done=0, pass=0, fail_mask=0 (and err_cnt=0 when present).
REQ-032 Any run interrupted by reset SHALL be abandoned and produce no done pulse.
REQ-033 After rst_n deasserts, the block SHALL accept start at the first rising edge.

Configuration
REQ-034 Macro NOR_BIST_ERRCNT_EN SHALL control an extra output port err_cnt  output  4  saturating count of mismatching (unit, pattern) samples in the run.
REQ-035 With NOR_BIST_ERRCNT_EN defined, each CHECK SHALL add the number of mismatching bits of y to err_cnt, saturating at 15; err_cnt is cleared on accepted start and held after DONE.
REQ-036 Without NOR_BIST_ERRCNT_EN, the err_cnt port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-037 SHALL cover: HOLD=2, 4 correct NOR units, start pulse -> {a,b} = 00, 01, 10, 11 for 3 cycles each, done in cycle 13, pass=1, fail_mask=0000, err_cnt=0.
REQ-038 SHALL cover: unit 2 replaced by OR -> pass=0, fail_mask=0100, err_cnt=4.
REQ-039 SHALL cover: unit 0 output stuck at 1 -> fail_mask=0001, err_cnt=3 (mismatch on 01, 10, 11).
REQ-040 SHALL cover: y=xxxx for all patterns -> fail_mask=1111, err_cnt=15 (saturated from 16).
REQ-041 SHALL cover: start re-pulsed in cycle 5 of a run -> ignored, done still in cycle 13, no second run.
REQ-042 SHALL cover: rst_n pulled low in cycle 7 -> all outputs 0 immediately, no done; a new start after release gives a full clean run.
